// File: rtl/fpu_wb_count_monitor.sv
// Writeback-consistency monitor: compares the number of units reporting writeback-valid
// (optionally delayed) against the number of register-file write enables each cycle.
module fpu_wb_count_monitor #(
    parameter int N_UNITS      = 4,
    parameter int N_PORTS      = 1,
    parameter int WEN_LAG      = 0,
    parameter int MODE         = 0,
    parameter int CNT_W        = 8,
    parameter int CYC_W        = 32,
    parameter int FATAL_ON_ERR = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_UNITS-1:0] unit_valid,
    input  logic [N_PORTS-1:0] wb_wen,
    input  logic               check_bypass,
    input  logic               clear_err,
    output logic               err_pulse,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   err_count,
    output logic [N_UNITS-1:0] first_err_vec,
    output logic [N_PORTS-1:0] first_err_wen,
    output logic [CYC_W-1:0]   first_err_cycle
);

    localparam int VC_W  = $clog2(N_UNITS + 1);
    localparam int WC_W  = $clog2(N_PORTS + 1);
    localparam int CMP_W = (VC_W > WC_W) ? VC_W : WC_W;

    logic [N_UNITS-1:0] dly_valid;

    generate
        if (WEN_LAG == 0) begin : g_no_lag
            assign dly_valid = unit_valid;
        end else begin : g_lag
            logic [N_UNITS-1:0] lag_q [WEN_LAG];
            logic [N_UNITS-1:0] lag_d [WEN_LAG];

            always_comb begin
                lag_d[0] = unit_valid;
                for (int i = 1; i < WEN_LAG; i++) begin
                    lag_d[i] = lag_q[i-1];
                end
            end

            // Reset empties the pipeline so in-flight valids from before reset are discarded.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    for (int i = 0; i < WEN_LAG; i++) begin
                        lag_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WEN_LAG; i++) begin
                        lag_q[i] <= lag_d[i];
                    end
                end
            end

            assign dly_valid = lag_q[WEN_LAG-1];
        end
    endgenerate

    logic [CMP_W-1:0] vcnt;
    logic [CMP_W-1:0] wcnt;
    logic             mismatch;

    always_comb begin
        vcnt = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            vcnt = vcnt + CMP_W'(dly_valid[i]);
        end
        wcnt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            wcnt = wcnt + CMP_W'(wb_wen[i]);
        end
        if (check_bypass) begin
            mismatch = 1'b0;
        end else if (MODE == 0) begin
            mismatch = (vcnt != wcnt);
        end else begin
            mismatch = (vcnt > wcnt);
        end
    end

    logic               pulse_q,  pulse_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [N_UNITS-1:0] vec_q,    vec_d;
    logic [N_PORTS-1:0] wen_q,    wen_d;
    logic [CYC_W-1:0]   fcyc_q,   fcyc_d;
    logic [CYC_W-1:0]   cyc_q,    cyc_d;

    // A mismatch always takes priority over a same-cycle clear and restarts the capture.
    always_comb begin
        cyc_d    = cyc_q + CYC_W'(1);
        pulse_d  = mismatch;
        sticky_d = sticky_q;
        count_d  = count_q;
        vec_d    = vec_q;
        wen_d    = wen_q;
        fcyc_d   = fcyc_q;
        if (mismatch) begin
            sticky_d = 1'b1;
            if (clear_err) begin
                count_d = CNT_W'(1);
            end else if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
            if (!sticky_q || clear_err) begin
                vec_d  = dly_valid;
                wen_d  = wb_wen;
                fcyc_d = cyc_q;
            end
        end else if (clear_err) begin
            sticky_d = 1'b0;
            count_d  = '0;
            vec_d    = '0;
            wen_d    = '0;
            fcyc_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cyc_q    <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            vec_q    <= '0;
            wen_q    <= '0;
            fcyc_q   <= '0;
        end else begin
            cyc_q    <= cyc_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            vec_q    <= vec_d;
            wen_q    <= wen_d;
            fcyc_q   <= fcyc_d;
        end
    end

    assign err_pulse       = pulse_q;
    assign err_sticky      = sticky_q;
    assign err_count       = count_q;
    assign first_err_vec   = vec_q;
    assign first_err_wen   = wen_q;
    assign first_err_cycle = fcyc_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (FATAL_ON_ERR != 0 && reset_n && pulse_q) begin
            $display("fpu_wb_count_monitor: writeback count mismatch, cycle %0d", fcyc_q);
            $fatal(1, "fpu_wb_count_monitor: writeback count mismatch");
        end
    end
`endif

endmodule
